spi_master_tx: RTL

//   SPI master transmitter. Accepts a DATA_W-bit word over a valid/ready handshake and

---
 rtl/spi_master_tx_if.sv | 24 ++
 rtl/spi_master_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx_if.sv
// Host-side bundle for the SPI master transmitter: word handshake plus the serial pins.
// The slave modport is the transmitter itself; master is the block that feeds it words.
interface spi_master_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic              cs_n;
  logic              sclk;
  logic              sdo;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, cs_n, sclk, sdo
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, cs_n, sclk, sdo
  );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: takes one word per handshake and shifts it out MSB-first,
// framing it with cs_n setup/hold margins and a minimum inter-frame cs_n-high gap.
module spi_master_tx #(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 8
) (
  input logic              clk,
  input logic              rst,
  spi_master_tx_if.slave   bus
);

  localparam int M1      = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int M2      = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_W);
  // The IDLE cycle that presents tx_ready also keeps cs_n high, so GAP is one shorter.
  localparam int GAP_LEN = (CS_IDLE > 1) ? CS_IDLE - 1 : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              phase_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              sdo_q, sdo_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The shift register is only read after a handshake has loaded it.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    phase_d = sclk_q;
    unique case (state_q)
      IDLE: begin
        if (bus.tx_valid && ready_q) begin
          state_d = SETUP;
          cnt_d   = '0;
          shreg_d = bus.tx_data;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!sclk_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            // Last bit stays on sdo through HOLD; otherwise advance with the falling edge.
            if (bit_q == BIT_W'(DATA_W - 1)) begin
              state_d = HOLD;
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_n_d  = 1'b1;
    sclk_d  = 1'b0;
    sdo_d   = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    unique case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      SETUP, HOLD: begin
        cs_n_d = 1'b0;
        sdo_d  = shreg_d[DATA_W-1];
      end
      SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = phase_d;
        sdo_d  = shreg_d[DATA_W-1];
      end
      GAP: done_d = (state_q == HOLD);
      default: ;
    endcase
  end

  assign bus.tx_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.sclk     = sclk_q;
  assign bus.sdo      = sdo_q;

endmodule
